// File: rtl/fn1_mac_pkg.sv
// fn1_mac_pkg: shared constants, types and the output clamp helper for the
// fn1 multiply-accumulate stage.
//
// Contents:
//   DIN_WIDTH, ACC_WIDTH, OUT_WIDTH, CNT_WIDTH, MUL_LATENCY  default widths
//   grp_state_t   group state: IDLE (next product opens a group) / ACCUM
//   sat_res_t     clamped result plus overflow flag
//   sat_to_out()  clamps an ACC_WIDTH signed value into OUT_WIDTH signed range
//
// sat_to_out() is built at the package widths. The saturating build of the top
// (FN1_MAC_ACC_SAT_EN) relies on the top's ACC_WIDTH/OUT_WIDTH matching them.
package fn1_mac_pkg;

    localparam int DIN_WIDTH   = 31;
    localparam int ACC_WIDTH   = 40;
    localparam int OUT_WIDTH   = 32;
    localparam int CNT_WIDTH   = 10;
    localparam int MUL_LATENCY = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } grp_state_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 ovf;
    } sat_res_t;

    // Largest / smallest value representable in OUT_WIDTH, held at ACC_WIDTH.
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    function automatic sat_res_t sat_to_out(input logic signed [ACC_WIDTH-1:0] acc);
        sat_res_t res;
        res.data = acc[OUT_WIDTH-1:0];
        res.ovf  = 1'b0;
        if (acc > SAT_HI) begin
            res.data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            res.ovf  = 1'b1;
        end else if (acc < SAT_LO) begin
            res.data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            res.ovf  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fn1_mac_acc_31s_if.sv
// fn1_mac_acc_31s_if: operand-side, multiplier-side and result-side signals of
// the fn1 accumulate stage.
//
// Signals:
//   in_valid, in_last, in_ready          operand pair handshake (last closes a group)
//   mul_ce, mul_dout                     multiplier clock enable and product
//   out_valid, out_ready                 result handshake
//   out_data, out_count, out_ovf         group sum, product count, clamp flag
// Modports:
//   slave   the accumulate stage
//   master  the environment (operand source, multiplier, result sink)
interface fn1_mac_acc_31s_if #(
    parameter int DIN_WIDTH = fn1_mac_pkg::DIN_WIDTH,
    parameter int OUT_WIDTH = fn1_mac_pkg::OUT_WIDTH,
    parameter int CNT_WIDTH = fn1_mac_pkg::CNT_WIDTH
);
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic                 mul_ce;
    logic [DIN_WIDTH-1:0] mul_dout;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport slave (
        input  in_valid, in_last, mul_dout, out_ready,
        output in_ready, mul_ce, out_valid, out_data, out_count, out_ovf
    );

    modport master (
        output in_valid, in_last, mul_dout, out_ready,
        input  in_ready, mul_ce, out_valid, out_data, out_count, out_ovf
    );

endinterface

// File: rtl/fn1_mac_vld_pipe.sv
// fn1_mac_vld_pipe: clock-enabled {valid, last} delay line that tracks operand
// pairs through the multiplier so the tail lines up with the product on dout.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   ce                      shift enable (same enable as the multiplier)
//   in_valid, in_last       stage-0 inputs
//   tail_valid, tail_last   last-stage outputs
module fn1_mac_vld_pipe #(
    parameter int DEPTH = fn1_mac_pkg::MUL_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic in_valid,
    input  logic in_last,
    output logic tail_valid,
    output logic tail_last
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every pipe bit is reset, so the unreset multiplier's stale
            // contents never reach the accumulator after reset.
            vld_q  <= '0;
            last_q <= '0;
        end else if (ce) begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, so loop order does not matter.
            vld_q[0]  <= in_valid;
            last_q[0] <= in_last;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign tail_valid = vld_q[DEPTH-1];
    assign tail_last  = last_q[DEPTH-1];

endmodule

// File: rtl/fn1_mac_acc_31s.sv
// fn1_mac_acc_31s: accumulate stage behind the fn1 signed 16x15 pipelined
// multiplier. Drives the multiplier clock enable, tracks operand validity and
// group boundaries through the multiplier latency, sums each group's products
// into a wide accumulator and emits one result per group.
//
// Ports:
//   clk     rising-edge clock shared with the multiplier
//   reset   asynchronous active-low reset
//   bus     fn1_mac_acc_31s_if.slave (operand, multiplier and result signals)
//
// Build option: define FN1_MAC_ACC_SAT_EN to clamp out_data into the
// OUT_WIDTH signed range and flag it on out_ovf; otherwise out_data is the
// two's-complement truncation of the sum and out_ovf is 0.
module fn1_mac_acc_31s
    import fn1_mac_pkg::*;
#(
    parameter int DIN_WIDTH   = fn1_mac_pkg::DIN_WIDTH,
    parameter int ACC_WIDTH   = fn1_mac_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = fn1_mac_pkg::OUT_WIDTH,
    parameter int MUL_LATENCY = fn1_mac_pkg::MUL_LATENCY,
    parameter int CNT_WIDTH   = fn1_mac_pkg::CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    fn1_mac_acc_31s_if.slave bus
);
    logic                 stall;
    logic                 ce;
    logic                 accept;
    logic                 tail_valid;
    logic                 tail_last;
    logic                 tail_ev;

    grp_state_t           state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_next;

    logic [OUT_WIDTH-1:0] res_data;
    logic                 res_ovf;

    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_ovf_q;

    // A held, unaccepted result freezes the multiplier and the valid pipe
    // together, so products stay aligned with their tags.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign ce           = ~stall;
    assign bus.mul_ce   = ce;
    assign bus.in_ready = ce;
    assign accept       = bus.in_valid & ce;

    fn1_mac_vld_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_vld_pipe (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (accept),
        .in_last    (bus.in_last),
        .tail_valid (tail_valid),
        .tail_last  (tail_last)
    );

    assign tail_ev = tail_valid & ce;

    always_comb begin
        // NOTE: both outputs are assigned on every path, so no latch is inferred.
        acc_next = ((state_q == ST_IDLE) ? '0 : acc_q)
                 + {{(ACC_WIDTH-DIN_WIDTH){bus.mul_dout[DIN_WIDTH-1]}}, bus.mul_dout};
        if (state_q == ST_IDLE)
            cnt_next = CNT_WIDTH'(1);
        else if (&cnt_q)
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + CNT_WIDTH'(1);
    end

`ifdef FN1_MAC_ACC_SAT_EN
    sat_res_t sat;
    assign sat      = sat_to_out(acc_next);
    assign res_data = sat.data;
    assign res_ovf  = sat.ovf;
`else
    assign res_data = acc_next[OUT_WIDTH-1:0];
    assign res_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (tail_ev) begin
                acc_q   <= acc_next;
                cnt_q   <= cnt_next;
                state_q <= tail_last ? ST_IDLE : ST_ACCUM;
            end
            // A result handed over this cycle releases the stall, so a new
            // result may load on the same edge and out_valid stays high.
            if (tail_ev && tail_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                out_count_q <= cnt_next;
                out_ovf_q   <= res_ovf;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fn1_mac_acc_31s.sv
// tb_fn1_mac_acc_31s: self-checking bench for fn1_mac_acc_31s. A stand-in
// multiplier (ce-gated delay line, no reset) delivers products presented on
// mul_din. A scoreboard sums each accepted group with plain integer arithmetic
// and checks every result handshake; directed sequences pin exact values.
module tb_fn1_mac_acc_31s;
    import fn1_mac_pkg::*;

    localparam int LAT = MUL_LATENCY;

    typedef struct {
        logic [31:0] data;
        logic [9:0]  count;
        logic        ovf;
    } result_t;

    logic clk;
    logic reset;
    logic signed [30:0] mul_din;
    logic signed [30:0] mul_pipe [LAT];

    fn1_mac_acc_31s_if bus ();

    fn1_mac_acc_31s dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier: LAT ce-enabled stages, deliberately not reset.
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            mul_pipe[0] <= mul_din;
            for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign bus.mul_dout = mul_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected output for a group sum: wrap to the accumulator width, then
    // clamp or truncate to 32 bits.
    function automatic result_t model_result(input longint sum, input int cnt);
        result_t r;
        longint  a;
        a = (sum <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
        r.ovf  = 1'b0;
        r.data = a[31:0];
`ifdef FN1_MAC_ACC_SAT_EN
        if (a > 64'sd2147483647) begin
            r.data = 32'h7FFF_FFFF;
            r.ovf  = 1'b1;
        end else if (a < -64'sd2147483648) begin
            r.data = 32'h8000_0000;
            r.ovf  = 1'b1;
        end
`endif
        r.count = (cnt > 1023) ? 10'd1023 : 10'(cnt);
        return r;
    endfunction

    // Scoreboard / compare process, sampled on the falling edge.
    result_t     exp_q [$];
    longint      grp_sum   = 0;
    int          grp_cnt   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [9:0]  prev_count;
    logic        prev_ovf;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            grp_sum    = 0;
            grp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            check("ready_ce", {bus.in_ready, bus.mul_ce},
                  (bus.out_valid && !bus.out_ready) ? 2'b00 : 2'b11);
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_count", bus.out_count, prev_count);
                check("hold_ovf", bus.out_ovf, prev_ovf);
            end
            if (bus.in_valid && bus.in_ready) begin
                grp_sum += longint'(mul_din);
                grp_cnt++;
                if (bus.in_last) begin
                    exp_q.push_back(model_result(grp_sum, grp_cnt));
                    grp_sum = 0;
                    grp_cnt = 0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                check("result_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    result_t e;
                    e = exp_q.pop_front();
                    check("sb_data", bus.out_data, e.data);
                    check("sb_count", bus.out_count, e.count);
                    check("sb_ovf", bus.out_ovf, e.ovf);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_count = bus.out_count;
            prev_ovf   = bus.out_ovf;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and return #1 after the edge that accepts it.
    task automatic send(input logic signed [30:0] p, input logic last);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        mul_din      = p;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
            if (ok) break;
        end
        if (!ok) check("send_accept", ok, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait on falling edges for out_valid; cyc is the falling edge it was seen on.
    task automatic wait_valid(input string name, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) check({name, "_seen"}, bus.out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        mul_din       = '0;

        // Reset state.
        #12;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_mul_ce", bus.mul_ce, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_count", bus.out_count, 10'd0);
        check("rst_out_ovf", bus.out_ovf, 1'b0);
        #10 reset = 1'b1;
        step();
        step();

        // Group of three: 100 - 40 + 7 = 67, out_valid LAT+1 cycles after the
        // cycle in which the last pair is presented.
        send(31'sd100, 1'b0);
        send(-31'sd40, 1'b0);
        send(31'sd7, 1'b1);
        wait_valid("grp3", cyc);
        check("grp3_latency", cyc, 4);
        check("grp3_data", bus.out_data, 32'd67);
        check("grp3_count", bus.out_count, 10'd3);
        step();

        // Back-to-back single-product groups; the second result loads while the
        // first is being accepted.
        send(31'sd5, 1'b1);
        send(-31'sd5, 1'b1);
        wait_valid("b2b", cyc);
        check("b2b_data0", bus.out_data, 32'd5);
        check("b2b_count0", bus.out_count, 10'd1);
        @(negedge clk);
        check("b2b_valid1", bus.out_valid, 1'b1);
        check("b2b_data1", bus.out_data, 32'hFFFF_FFFB);
        check("b2b_count1", bus.out_count, 10'd1);
        step();
        step();

        // Backpressure: result held, pipe frozen with a product at the tail.
        bus.out_ready = 1'b0;
        send(31'sd11, 1'b0);
        send(31'sd22, 1'b1);
        send(31'sd3, 1'b1);
        wait_valid("bp", cyc);
        check("bp_data", bus.out_data, 32'd33);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_mul_ce", bus.mul_ce, 1'b0);
            check("bp_data_held", bus.out_data, 32'd33);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_valid", bus.out_valid, 1'b1);
        check("bp_next_data", bus.out_data, 32'd3);
        check("bp_next_count", bus.out_count, 10'd1);
        step();
        step();

        // Saturation boundary: 4 x 0x3FFF_FFFF = 0xFFFF_FFFC.
        for (int i = 0; i < 4; i++) send(31'sh3FFF_FFFF, (i == 3));
        wait_valid("sat", cyc);
`ifdef FN1_MAC_ACC_SAT_EN
        check("sat_data", bus.out_data, 32'h7FFF_FFFF);
        check("sat_ovf", bus.out_ovf, 1'b1);
`else
        check("sat_data", bus.out_data, 32'hFFFF_FFFC);
        check("sat_ovf", bus.out_ovf, 1'b0);
`endif
        check("sat_count", bus.out_count, 10'd4);
        step();

        // Reset in the middle of a group.
        send(31'sd1000, 1'b0);
        send(31'sd2000, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        send(31'sd9, 1'b1);
        wait_valid("mid_rst", cyc);
        check("mid_rst_data", bus.out_data, 32'd9);
        check("mid_rst_count", bus.out_count, 10'd1);
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        check("mid_rst_single", bus.out_valid, 1'b0);
        step();

        // Count saturation: 1030 products of 1 in one group.
        for (int i = 0; i < 1030; i++) send(31'sd1, (i == 1029));
        wait_valid("long", cyc);
        check("long_count", bus.out_count, 10'd1023);
        check("long_data", bus.out_data, 32'd1030);
        step();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_last   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                mul_din = 31'($urandom);
            else
                mul_din = 31'(int'($urandom_range(0, 2000)) - 1000);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        send(31'sd0, 1'b1);
        for (int i = 0; i < 30; i++) step();
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 0);
        check("drain_valid", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
